// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA joystick scanner: scan states, idle bus
// levels and bit positions on the shared joystick bus.
package jamma_pkg;

    typedef enum logic [1:0] {
        SETTLE_P1 = 2'd0,
        SAMPLE_P1 = 2'd1,
        SETTLE_P2 = 2'd2,
        SAMPLE_P2 = 2'd3
    } scan_state_t;

    localparam logic [7:0] JOY_RELEASED  = 8'hFF;
    localparam logic [1:0] COIN_RELEASED = 2'b11;

    localparam int START_BIT = 7;
    localparam int BTN0_BIT  = 0;
    localparam int BTN1_BIT  = 1;
    localparam int BTN2_BIT  = 2;
    localparam int BTN3_BIT  = 3;
    localparam int BTN4_BIT  = 4;
    localparam int BTN5_BIT  = 5;

    // Active-low inputs: a press on either the JAMMA bus or the local DB9
    // stick pulls the merged bit low. Bits above the DB9 range pass through.
    function automatic logic [7:0] merge_local(input logic [7:0] bus,
                                               input logic [5:0] local_joy);
        logic [7:0] merged;
        merged = bus;
        merged[BTN5_BIT:BTN0_BIT] = bus[BTN5_BIT:BTN0_BIT] & local_joy;
        return merged;
    endfunction

endpackage

// File: rtl/jamma_debounce.sv
// Whole-vector debouncer: the output only takes a new value after that value
// has been sampled DEBOUNCE_SAMPLES times in a row.
module jamma_debounce #(
    parameter int W                = 8,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic [W-1:0] sample,
    output logic [W-1:0] out,
    output logic         changed
);

    localparam int            CW     = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_SAMPLES);

    logic [W-1:0]  shadow;
    logic [W-1:0]  shadow_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    // A differing sample restarts the run at one; a matching sample extends
    // it, saturating at TARGET so the counter never wraps.
    always_comb begin
        shadow_nxt = shadow;
        count_nxt  = count;
        if (sample_en) begin
            if (sample != shadow) begin
                shadow_nxt = sample;
                count_nxt  = CW'(1);
            end else if (count != TARGET) begin
                count_nxt = count + CW'(1);
            end
        end
    end

    assign changed = sample_en && (count_nxt == TARGET) && (shadow_nxt != out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '1;
            count  <= '0;
            out    <= '1;
        end else begin
            shadow <= shadow_nxt;
            count  <= count_nxt;
            if (changed) begin
                out <= shadow_nxt;
            end
        end
    end

endmodule

// File: rtl/jamma_input_scanner.sv
// Scans the shared JAMMA joystick bus for both players with a settle delay
// before each sample, then debounces P1, P2 and coin vectors independently.
module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] jjoy_i,
    input  logic [1:0] jcoin_i,
    input  logic [5:0] local_joy_i,
    output logic       jselect_o,
    output logic [7:0] joy1_o,
    output logic [7:0] joy2_o,
    output logic [1:0] coin_o,
    output logic       update_o
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    scan_state_t state;
    scan_state_t state_nxt;
    logic [3:0]  settle_cnt;
    logic [3:0]  settle_cnt_nxt;
    logic        jselect_q;

    logic        p1_sample_en;
    logic        p2_sample_en;
    logic [7:0]  p1_sample;
    logic        p1_changed;
    logic        p2_changed;
    logic        coin_changed;

    // Select is registered from the next state so it moves on the same edge
    // that leaves a sample state, without decode glitches on the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SETTLE_P1;
            settle_cnt <= '0;
            jselect_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            jselect_q  <= (state_nxt == SETTLE_P2) || (state_nxt == SAMPLE_P2);
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        if (ena) begin
            unique case (state)
                SETTLE_P1: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt      = SAMPLE_P1;
                        settle_cnt_nxt = '0;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 4'd1;
                    end
                end
                SAMPLE_P1: state_nxt = SETTLE_P2;
                SETTLE_P2: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt      = SAMPLE_P2;
                        settle_cnt_nxt = '0;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 4'd1;
                    end
                end
                SAMPLE_P2: state_nxt = SETTLE_P1;
                default:   state_nxt = SETTLE_P1;
            endcase
        end
    end

    assign p1_sample_en = ena && (state == SAMPLE_P1);
    assign p2_sample_en = ena && (state == SAMPLE_P2);
    assign p1_sample    = merge_local(jjoy_i, local_joy_i);

    jamma_debounce #(
        .W               (8),
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce_p1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(p1_sample_en),
        .sample   (p1_sample),
        .out      (joy1_o),
        .changed  (p1_changed)
    );

    jamma_debounce #(
        .W               (8),
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce_p2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(p2_sample_en),
        .sample   (jjoy_i),
        .out      (joy2_o),
        .changed  (p2_changed)
    );

    // Coins are not multiplexed; sampling them with P1 keeps one coin sample per scan.
    jamma_debounce #(
        .W               (2),
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce_coin (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(p1_sample_en),
        .sample   (jcoin_i),
        .out      (coin_o),
        .changed  (coin_changed)
    );

    assign jselect_o = jselect_q;
    assign update_o  = p1_changed | p2_changed | coin_changed;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Scoreboard bench for jamma_input_scanner: a sample-history model predicts
// every debounced commit, and a monitor checks each update_o pulse against it.
module tb_jamma_input_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int PERIOD = 2 * (SETTLE + 1);

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] jjoy_i;
    logic [1:0] jcoin_i;
    logic [5:0] local_joy_i;
    logic       jselect_o;
    logic [7:0] joy1_o;
    logic [7:0] joy2_o;
    logic [1:0] coin_o;
    logic       update_o;

    jamma_input_scanner #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_SAMPLES(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .jjoy_i     (jjoy_i),
        .jcoin_i    (jcoin_i),
        .local_joy_i(local_joy_i),
        .jselect_o  (jselect_o),
        .joy1_o     (joy1_o),
        .joy2_o     (joy2_o),
        .coin_o     (coin_o),
        .update_o   (update_o)
    );

    typedef struct {
        int         cyc;
        logic [7:0] j1;
        logic [7:0] j2;
        logic [1:0] c;
    } exp_t;

    exp_t       sb[$];
    exp_t       item;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         mon_cyc;
    int         e = 0;
    logic [7:0] hist1[$];
    logic [7:0] hist2[$];
    logic [1:0] histc[$];
    logic [7:0] m_joy1 = 8'hFF;
    logic [7:0] m_joy2 = 8'hFF;
    logic [1:0] m_coin = 2'b11;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] cn;
    logic [5:0] lj;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every scan position is a fixed enabled-cycle offset;
    // a channel's output takes a value once the last DEB samples all equal it.
    task automatic modelStep(input logic [7:0] p1v, input logic [7:0] p2v,
                             input logic [1:0] coinv, input logic [5:0] locv);
        int  ph;
        bit  ok;
        bit  any;
        logic [7:0] v;
        logic [1:0] vc;
        ph  = e % PERIOD;
        any = 0;
        if (ph == SETTLE) begin
            v = p1v & {2'b11, locv};
            hist1.push_back(v);
            if (hist1.size() > DEB) void'(hist1.pop_front());
            ok = (hist1.size() == DEB);
            foreach (hist1[k]) if (hist1[k] != v) ok = 0;
            if (ok && v != m_joy1) begin
                m_joy1 = v;
                any = 1;
            end
            vc = coinv;
            histc.push_back(vc);
            if (histc.size() > DEB) void'(histc.pop_front());
            ok = (histc.size() == DEB);
            foreach (histc[k]) if (histc[k] != vc) ok = 0;
            if (ok && vc != m_coin) begin
                m_coin = vc;
                any = 1;
            end
        end else if (ph == PERIOD - 1) begin
            v = p2v;
            hist2.push_back(v);
            if (hist2.size() > DEB) void'(hist2.pop_front());
            ok = (hist2.size() == DEB);
            foreach (hist2[k]) if (hist2[k] != v) ok = 0;
            if (ok && v != m_joy2) begin
                m_joy2 = v;
                any = 1;
            end
        end
        if (any) sb.push_back('{cyc, m_joy1, m_joy2, m_coin});
        e++;
    endtask

    // Called at posedge+1; drives one cycle and returns at the next posedge+1.
    task automatic applyStimulus(input bit en, input logic [7:0] p1v, input logic [7:0] p2v,
                                 input logic [1:0] coinv, input logic [5:0] locv);
        ena         = en;
        jcoin_i     = coinv;
        local_joy_i = locv;
        jjoy_i      = jselect_o ? p2v : p1v;
        checkOutput("jselect", {31'b0, jselect_o}, ((e % PERIOD) > SETTLE) ? 32'd1 : 32'd0);
        if (en) modelStep(p1v, p2v, coinv, locv);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        checkOutput("sb_drained", sb.size(), 0);
        sb.delete();
        rst_n = 1'b0;
        hist1.delete();
        hist2.delete();
        histc.delete();
        m_joy1 = 8'hFF;
        m_joy2 = 8'hFF;
        m_coin = 2'b11;
        e = 0;
        #1;
        checkOutput("reset_joy1", joy1_o, 8'hFF);
        checkOutput("reset_joy2", joy2_o, 8'hFF);
        checkOutput("reset_coin", coin_o, 2'b11);
        checkOutput("reset_jselect", jselect_o, 0);
        checkOutput("reset_update", update_o, 0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] randJoy();
        logic [7:0] v;
        v = 8'hFF;
        v[$urandom_range(0, 7)] = 1'b0;
        if ($urandom_range(0, 1) == 1) v[$urandom_range(0, 7)] = 1'b0;
        return v;
    endfunction

    // Monitor: each update_o pulse must match the oldest predicted commit,
    // both in cycle and in the values visible after the committing edge.
    initial begin
        forever begin
            @(negedge clk);
            if (update_o === 1'b1) begin
                mon_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_update: update_o=1 at cycle %0d, required 0", mon_cyc);
                end else begin
                    item = sb.pop_front();
                    @(posedge clk);
                    #2;
                    checkOutput("commit_cycle", mon_cyc, item.cyc);
                    checkOutput("commit_joy1", joy1_o, item.j1);
                    checkOutput("commit_joy2", joy2_o, item.j2);
                    checkOutput("commit_coin", coin_o, item.c);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                item = sb.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed_update: update_o=0 at cycle %0d, required 1", item.cyc);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        jjoy_i      = 8'h00;
        jcoin_i     = 2'b00;
        local_joy_i = 6'h00;
        @(posedge clk);
        #1;
        $display("[TB] reset with bus driven low");
        applyReset(3);

        $display("[TB] P1 press on bus");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'hFE, 8'hFF, 2'b11, 6'h3F);
        checkOutput("p1_press_joy1", joy1_o, 8'hFE);
        checkOutput("p1_press_joy2", joy2_o, 8'hFF);

        $display("[TB] P2 one-scan glitch");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'hFE, 8'hF7, 2'b11, 6'h3F);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 8'hFE, 8'hFF, 2'b11, 6'h3F);
        checkOutput("glitch_joy2", joy2_o, 8'hFF);

        $display("[TB] local joystick merge");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'hFF, 8'hFF, 2'b11, 6'b111101);
        checkOutput("merge_joy1", joy1_o, 8'hFD);
        checkOutput("merge_joy2", joy2_o, 8'hFF);

        $display("[TB] coin with ena toggling");
        for (int i = 0; i < 80; i++) applyStimulus((i % 2) == 0, 8'hFF, 8'hFF, 2'b10, 6'h3F);
        checkOutput("coin_gated", coin_o, 2'b10);

        $display("[TB] randomized traffic");
        p1 = 8'hFF;
        p2 = 8'hFF;
        cn = 2'b10;
        lj = 6'h3F;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) p1 = randJoy();
            if ($urandom_range(0, 59) == 0) p2 = randJoy();
            if ($urandom_range(0, 79) == 0) cn = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) lj = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'(~(6'h1 << $urandom_range(0, 5)));
            if ($urandom_range(0, 49) == 0) p1 = 8'hFF;
            applyStimulus($urandom_range(0, 3) != 0, p1, p2, cn, lj);
        end

        $display("[TB] reset during P2 sample");
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'hFF, 8'h7F, 2'b11, 6'h3F);
        checkOutput("pre_reset_joy2", joy2_o, 8'h7F);
        while ((e % PERIOD) != PERIOD - 1) applyStimulus(1'b1, 8'hFF, 8'h7F, 2'b11, 6'h3F);
        applyReset(2);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'hFF, 8'h7F, 2'b11, 6'h3F);
        checkOutput("post_reset_joy2", joy2_o, 8'h7F);

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hFF, 8'h7F, 2'b11, 6'h3F);
        checkOutput("sb_final_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
